// File: rtl/alu_display_sequencer_if.sv
// Bus bundle between the ALU board logic and the display sequencer.
// The master side drives operands, result and strobes; the slave side
// (the sequencer) returns the scanned digit code, anodes and status.
interface alu_display_sequencer_if #(
    parameter int RESULT_W = 6
);
    logic                tick;
    logic                load;
    logic [2:0]          port_a;
    logic [2:0]          port_b;
    logic [RESULT_W-1:0] result;
    logic [3:0]          bcd;
    logic [3:0]          an;
    logic                busy;
    logic                valid;

    modport master (
        output tick, load, port_a, port_b, result,
        input  bcd, an, busy, valid
    );

    modport slave (
        input  tick, load, port_a, port_b, result,
        output bcd, an, busy, valid
    );
endinterface

// File: rtl/alu_display_sequencer.sv
// Four-digit multiplexed display sequencer for the ALU board.
// A sequential double-dabble engine converts the binary result into two
// BCD digits; the digits are copied to shadow registers only when the
// conversion completes, so the scan never shows a half-converted value.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a load request; display shows shadow registers
// CONV  | one shift-add-3 step per cycle, RESULT_W cycles in total
// DONE  | single cycle: scratch digits copied to shadow, valid set
module alu_display_sequencer #(
    parameter int          RESULT_W   = 6,
    parameter logic [3:0]  BLANK_CODE = 4'hF,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    alu_display_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] LAST_CNT = 3'(RESULT_W - 1);

    state_e              state_q, state_d;
    logic [RESULT_W-1:0] shift_q, shift_d;
    logic [7:0]          scratch_q, scratch_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [3:0]          tens_q, ones_q;
    logic                valid_q;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          an_q, an_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [3:0]          adj_tens, adj_ones;
    logic                busy, start, conv_en, done;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load seen outside IDLE is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = CONV;
            CONV:    if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy    = (state_q != IDLE);
        start   = (state_q == IDLE) && bus.load;
        conv_en = (state_q == CONV);
        done    = (state_q == DONE);
    end

    // Double-dabble step: correct each nibble >= 5 by +3, then shift the
    // scratch/binary pair left so the next binary bit enters the ones digit.
    always_comb begin
        adj_ones  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        adj_tens  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        if (start) begin
            shift_d   = bus.result;
            scratch_d = 8'h00;
            cnt_d     = 3'd0;
        end else if (conv_en) begin
            {scratch_d, shift_d} = {adj_tens, adj_ones, shift_q} << 1;
            cnt_d                = cnt_q + 3'd1;
        end
    end

    // Conversion scratch registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            scratch_q <= 8'h00;
            cnt_q     <= 3'd0;
        end else begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
        end
    end

    // Shadow digits and sticky valid, updated only on the completion cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_q  <= 4'h0;
            ones_q  <= 4'h0;
            valid_q <= 1'b0;
        end else if (done) begin
            tens_q  <= scratch_q[7:4];
            ones_q  <= scratch_q[3:0];
            valid_q <= 1'b1;
        end
    end

    // Digit selection for the index the next tick will move to; uses the
    // shadow values as they stand before any same-edge update.
    always_comb begin
        idx_d = idx_q + 2'd1;
        an_d  = 4'b1111;
        bcd_d = BLANK_CODE;
        case (idx_d)
            2'd0: begin
                an_d  = 4'b1110;
                bcd_d = valid_q ? ones_q : BLANK_CODE;
            end
            2'd1: begin
                an_d  = 4'b1101;
                bcd_d = (!valid_q || (LZ_BLANK && tens_q == 4'h0)) ? BLANK_CODE : tens_q;
            end
            2'd2: begin
                an_d  = 4'b1011;
                bcd_d = {1'b0, bus.port_b};
            end
            default: begin
                an_d  = 4'b0111;
                bcd_d = {1'b0, bus.port_a};
            end
        endcase
    end

    // Scan registers; held between ticks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= 2'd3;
            an_q  <= 4'b1111;
            bcd_q <= 4'h0;
        end else if (bus.tick) begin
            idx_q <= idx_d;
            an_q  <= an_d;
            bcd_q <= bcd_d;
        end
    end

    assign bus.an    = an_q;
    assign bus.bcd   = bcd_q;
    assign bus.busy  = busy;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_alu_display_sequencer.sv
// Bench for the display sequencer: a constant vector table for the scan
// order after reset, hand-written multi-cycle sequences, then random
// traffic checked against a cycle-level behavioural model.
module tb_alu_display_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_display_sequencer_if #(.RESULT_W(6)) ifa ();
    alu_display_sequencer_if #(.RESULT_W(6)) ifb ();

    alu_display_sequencer #(.RESULT_W(6), .BLANK_CODE(4'hF), .LZ_BLANK(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa.slave)
    );

    alu_display_sequencer #(.RESULT_W(6), .BLANK_CODE(4'hF), .LZ_BLANK(1'b0)) dut_nlz (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb.slave)
    );

    assign ifb.tick   = ifa.tick;
    assign ifb.load   = ifa.load;
    assign ifb.port_a = ifa.port_a;
    assign ifb.port_b = ifa.port_b;
    assign ifb.result = ifa.result;

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: conversion is result/10 and result%10, landing
    // RESULT_W+1 edges after an accepted load.
    int         m_idx = 3;
    logic [3:0] m_an = 4'hF;
    logic [3:0] m_bcd = 4'h0;
    logic [3:0] m_bcd_nlz = 4'h0;
    int         m_tens = 0;
    int         m_ones = 0;
    bit         m_valid = 1'b0;
    int         m_cnt = 0;
    int         m_pend = 0;

    function automatic logic [3:0] model_code(int idx, bit lz, int pa, int pb,
                                              bit v, int tens, int ones);
        case (idx)
            0:       return v ? 4'(ones) : 4'hF;
            1:       return (!v || (lz && tens == 0)) ? 4'hF : 4'(tens);
            2:       return 4'(pb);
            default: return 4'(pa);
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit l,
                              input int res, input int pa, input int pb);
        if (r) begin
            m_idx = 3; m_an = 4'hF; m_bcd = 4'h0; m_bcd_nlz = 4'h0;
            m_tens = 0; m_ones = 0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            if (t) begin
                m_idx     = (m_idx + 1) % 4;
                m_an      = ~(4'b0001 << m_idx);
                m_bcd     = model_code(m_idx, 1'b1, pa, pb, m_valid, m_tens, m_ones);
                m_bcd_nlz = model_code(m_idx, 1'b0, pa, pb, m_valid, m_tens, m_ones);
            end
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_tens  = m_pend / 10;
                    m_ones  = m_pend % 10;
                    m_valid = 1'b1;
                end
            end else if (l) begin
                m_pend = res;
                m_cnt  = 7;
            end
        end
    endtask

    task automatic check_model(input string name);
        bit ok;
        ok = (ifa.an == m_an) && (ifa.bcd == m_bcd) && (ifa.busy == (m_cnt > 0))
             && (ifa.valid == m_valid) && (ifb.bcd == m_bcd_nlz) && (ifa.an != 4'b0000);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s t=%0t: got an=%b bcd=%h busy=%b valid=%b bcd_nlz=%h, want an=%b bcd=%h busy=%b valid=%b bcd_nlz=%h",
                      name, $time, ifa.an, ifa.bcd, ifa.busy, ifa.valid, ifb.bcd,
                      m_an, m_bcd, (m_cnt > 0), m_valid, m_bcd_nlz);
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    endtask

    // One clock: drive inputs, advance model with the edge, check #1 later.
    task automatic cyc(input bit r, input bit t, input bit l, input int res,
                       input int pa, input int pb, input string name);
        rst        = r;
        ifa.tick   = t;
        ifa.load   = l;
        ifa.result = 6'(res);
        ifa.port_a = 3'(pa);
        ifa.port_b = 3'(pb);
        @(posedge clk);
        model_step(r, t, l, res, pa, pb);
        #1;
        check_model(name);
    endtask

    typedef struct {
        bit         rst;
        bit         tick;
        logic [3:0] an;
        logic [3:0] bcd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;

        ifa.tick = 1'b0; ifa.load = 1'b0; ifa.result = '0;
        ifa.port_a = 3'd5; ifa.port_b = 3'd2;

        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'b1110, 4'hF};
        tbl[2]  = '{1'b0, 1'b0, 4'b1110, 4'hF};
        tbl[3]  = '{1'b0, 1'b1, 4'b1101, 4'hF};
        tbl[4]  = '{1'b0, 1'b1, 4'b1011, 4'h2};
        tbl[5]  = '{1'b0, 1'b1, 4'b0111, 4'h5};
        tbl[6]  = '{1'b0, 1'b1, 4'b1110, 4'hF};
        tbl[7]  = '{1'b0, 1'b1, 4'b1101, 4'hF};
        tbl[8]  = '{1'b0, 1'b1, 4'b1011, 4'h2};
        tbl[9]  = '{1'b0, 1'b1, 4'b0111, 4'h5};
        tbl[10] = '{1'b0, 1'b1, 4'b1110, 4'hF};

        // Reset and scan order before any conversion (PortA=5, PortB=2).
        cyc(1, 0, 0, 0, 5, 2, "reset_hold");
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; ifa.tick = tbl[i].tick; ifa.load = 1'b0;
            ifa.port_a = 3'd5; ifa.port_b = 3'd2;
            @(posedge clk);
            model_step(tbl[i].rst, tbl[i].tick, 1'b0, 0, 5, 2);
            #1;
            check_val($sformatf("tbl%0d_an", i), {4'h0, ifa.an}, {4'h0, tbl[i].an});
            check_val($sformatf("tbl%0d_bcd", i), {4'h0, ifa.bcd}, {4'h0, tbl[i].bcd});
            check_val($sformatf("tbl%0d_status", i), {6'h0, ifa.busy, ifa.valid}, 8'h00);
        end

        // Result=63: busy for 7 cycles, then tens 6 and ones 3. Scan is at index 0.
        cyc(0, 0, 1, 63, 5, 2, "load63");
        n = 0;
        while (ifa.busy && n < 20) begin
            n++;
            cyc(0, 0, 0, 0, 5, 2, "conv63");
        end
        check_val("busy_len63", 8'(n), 8'd7);
        check_val("valid63", {7'h0, ifa.valid}, 8'h01);
        cyc(0, 1, 0, 0, 5, 2, "tick63_1");
        check_val("tens63", {ifa.an, ifa.bcd}, {4'b1101, 4'h6});
        cyc(0, 1, 0, 0, 5, 2, "tick63_2");
        cyc(0, 1, 0, 0, 5, 2, "tick63_3");
        cyc(0, 1, 0, 0, 5, 2, "tick63_0");
        check_val("ones63", {ifa.an, ifa.bcd}, {4'b1110, 4'h3});

        // Result=7: leading-zero blanking on one instance only.
        cyc(0, 0, 1, 7, 5, 2, "load7");
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 5, 2, "conv7");
        cyc(0, 1, 0, 0, 5, 2, "tick7_1");
        check_val("lz_blank7", {ifa.an, ifa.bcd}, {4'b1101, 4'hF});
        check_val("no_lz7", {4'h0, ifb.bcd}, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 5, 2, "tick7");
        check_val("ones7", {ifa.an, ifa.bcd}, {4'b1110, 4'h7});

        // Load 42, then a load of 9 three cycles later is dropped.
        cyc(0, 0, 1, 42, 1, 6, "load42");
        cyc(0, 0, 0, 9, 1, 6, "conv42a");
        cyc(0, 0, 0, 9, 1, 6, "conv42b");
        cyc(0, 0, 1, 9, 1, 6, "load9_ignored");
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 9, 1, 6, "conv42");
        check_val("busy_after42", {7'h0, ifa.busy}, 8'h00);
        cyc(0, 1, 0, 0, 1, 6, "tick42_1");
        check_val("tens42", {4'h0, ifa.bcd}, 8'h04);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 6, "tick42");
        check_val("ones42", {4'h0, ifa.bcd}, 8'h02);

        // Reset during conversion of 50.
        cyc(0, 0, 1, 50, 3, 4, "load50");
        cyc(0, 0, 0, 50, 3, 4, "conv50");
        cyc(0, 0, 0, 50, 3, 4, "conv50");
        cyc(1, 0, 0, 50, 3, 4, "reset_mid");
        check_val("rst_mid", {ifa.an, 2'b00, ifa.busy, ifa.valid}, {4'b1111, 4'h0});
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 3, 4, "post_rst");
        check_val("post_rst_valid", {7'h0, ifa.valid}, 8'h00);

        // Tick on the DONE edge shows the old shadow digit.
        cyc(0, 0, 1, 11, 3, 4, "load11");
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 3, 4, "conv11");
        n = 0;
        while (m_idx != 3 && n < 8) begin
            n++;
            cyc(0, 1, 0, 0, 3, 4, "align");
        end
        cyc(0, 0, 1, 25, 3, 4, "load25");
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 3, 4, "conv25");
        cyc(0, 1, 0, 0, 3, 4, "tick_on_done");
        check_val("done_tick_old", {ifa.an, ifa.bcd}, {4'b1110, 4'h1});
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 3, 4, "tick25");
        check_val("done_tick_new", {ifa.an, ifa.bcd}, {4'b1110, 4'h5});

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 63)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)),
                "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_display_sequencer.md
Name: alu_display_sequencer

Overview:
Sequencing controller for the 4-digit multiplexed seven-segment display of the ALU board. Converts the 6-bit ALU result to two BCD digits with a sequential shift-add-3 (double-dabble) engine, double-buffered so the display never shows partial results. Scans the four digits (PortA, PortB, result tens, result ones) on a refresh tick from the frequency divider. Drives the BCD code and active-low anodes that feed the BCD-to-seven-segment converter.

Parameters:
RESULT_W, 6, result width in bits; legal range 1..6, so two BCD digits always suffice.
BLANK_CODE, 4'hF, BCD code the seven-segment converter renders as all segments off.
LZ_BLANK, 1, when 1, a zero tens digit is shown as BLANK_CODE.

Ports:
Clock  input  1  system clock; the only clock.
Reset  input  1  synchronous, active-high reset.
Tick  input  1  one-Clock-cycle refresh strobe from the frequency divider.
Load  input  1  one-cycle request to convert the current Result.
PortA  input  3  operand A, shown on digit 3.
PortB  input  3  operand B, shown on digit 2.
Result  input  RESULT_W  ALU result, binary.
BCD  output  4  code for the currently selected digit (registered).
An  output  4  anode enables, active-low, one-hot-low (registered).
Busy  output  1  conversion in progress.
Valid  output  1  at least one conversion has completed since reset.

Behaviour:
- One clock domain. Everything samples on the rising edge of Clock. Reset is synchronous and active-high and overrides all other inputs.
- Reset values:
  - An=4'b1111, BCD=4'h0, Busy=0, Valid=0.
  - Scan index=3, state=IDLE.
  - Shadow (display) tens/ones=0. Scratch registers=0.
- FSM states: IDLE, CONV, DONE.
  - IDLE: when Load=1, capture Result into the shift register, clear the BCD scratch, set the bit counter to 0, go to CONV. Busy=1 from the next cycle.
  - CONV: each cycle, first add 3 to each scratch nibble that is >=5, then shift the {scratch, shift register} pair left by one. Increment the counter. After RESULT_W CONV cycles go to DONE.
  - DONE (one cycle): copy scratch tens/ones into the shadow registers. Set Valid=1, which stays sticky until Reset. Set Busy=0. Return to IDLE.
  - Latency: Load sampled at edge N. Shadow registers update and Busy falls at edge N+RESULT_W+1.
  - Load while Busy=1 is ignored. It is not queued.
- Result is sampled only at the Load edge. Changes to Result during CONV have no effect.
- Scan: on each Tick, the scan index advances to (index+1) mod 4. On the same edge, An and BCD are registered for the new index.
  - First Tick after reset selects index 0.
  - Between Ticks, An and BCD hold their values.
- Digit map (An active-low):
  - index 0: An=1110, ones.
  - index 1: An=1101, tens.
  - index 2: An=1011, {1'b0,PortB}.
  - index 3: An=0111, {1'b0,PortA}.
  - PortA and PortB are sampled on the Tick edge that selects them.
- Blanking:
  - While Valid=0, indices 0 and 1 output BLANK_CODE.
  - When LZ_BLANK=1 and the shadow tens=0, index 1 outputs BLANK_CODE.
  - Ones is never blanked once Valid=1.
- Simultaneous events:
  - Tick and Load on the same edge are both honoured.
  - Tick on the DONE edge uses the old shadow values. The new values appear on the next Tick.
- Reset mid-conversion aborts the conversion, clears the shadow registers and Valid, and returns to IDLE.
- Only one anode is ever low. An is never 4'b0000.

Test Plan:
- Reset, then Result=63 with a Load pulse -> Busy=1 for 7 cycles. Shadow tens=6, ones=3. Valid=1. Ticks show BCD 3,6 on An 1110,1101.
- Result=7, Load, LZ_BLANK=1 -> index 1 shows 4'hF, index 0 shows 4'h7. With LZ_BLANK=0, index 1 shows 4'h0.
- PortA=5, PortB=2, 9 Ticks after reset -> index/An sequence 0,1,2,3,0,1,2,3,0. Index 2 shows BCD=2, index 3 shows BCD=5. Before the first Load, indices 0 and 1 show 4'hF.
- Load (Result=42), then a second Load with Result=9 three cycles later -> second Load ignored. Shadow=4,2.
- Reset asserted during CONV of Result=50 -> next cycle An=1111, Busy=0, Valid=0. Shadow stays 0 after Reset is released.
- Tick on the DONE edge -> the displayed digit shows the old shadow value. The new value appears on the following Tick.
